seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Decodes a multiplexed, active-low 7-segment display bus back to hex nibbles.
//  It is the receive side of the team's hex->7-seg encoder and sits on a DE1-SoC
//  display bus as a monitor/self-check tap.
//  Each digit is debounced, decoded and stored. When every digit has been captured,
//  a complete frame is presented on a valid/ready output.
// PARAMETERS
//  DIGITS         6   number of multiplexed digits (1..8)
//  STABLE_CYCLES  4   identical consecutive samples required before commit (2..255)
// PORTS
//  clk        in   1          system clock
//  reset      in   1          synchronous, active-high reset
//  seg_n      in   7          segment lines, active low; bit0=top, 1=top-right,
//                             2=bot-right, 3=bottom, 4=bot-left, 5=top-left, 6=middle
//  dig_sel    in   DIGITS     one-hot digit enable, active high
//  value      out  4*DIGITS   decoded frame; digit i at [4i+3:4i]
//  blank      out  DIGITS     digit i displayed blank (all segments off)
//  err        out  DIGITS     digit i showed an undecodable pattern
//  out_valid  out  1          frame on value/blank/err is valid
//  out_ready  in   1          consumer accepts frame
//  overflow   out  1          sticky: a completed frame was dropped
// BEHAVIOUR
//  Reset: all outputs 0; slots, captured mask and counter cleared; FSM -> SETTLE.
//   Reset asserted mid-frame discards partial captures and any pending frame.
//  Input stage: {seg_n,dig_sel} registered once. Comparisons use the registered
//   sample against the previous registered sample.
//  Decode (seg_n hex -> nibble):
//   40->0  79->1  24->2  30->3  19->4  12->5  02->6  78->7
//   00->8  18->9  08->A  03->b  46->C  21->d  06->E  0E->F
//   7F -> nibble F with blank=1. Any other pattern -> nibble 0 with err=1.
//  FSM per sample stream:
//   SETTLE: cnt increments while sample==previous; it reloads to 1 on change.
//    When cnt==STABLE_CYCLES and dig_sel is one-hot:
//     - write nibble/blank/err into slot[i];
//     - set captured[i];
//     - go to HOLD.
//    If dig_sel is zero or multi-hot, the sample is ignored and cnt held at 1.
//   HOLD: there is no re-commit of the same sample. Any change -> SETTLE, cnt=1.
//  cnt saturates at STABLE_CYCLES, with width $clog2(STABLE_CYCLES+1).
//  Latency: an input held from edge t is committed into slot[i] at edge
//   t+STABLE_CYCLES, counted from the first edge that registers it.
//  A later commit to an already-captured digit overwrites that slot.
//  Frame: when captured becomes all-ones:
//   - if out_valid==0 or out_ready==1 in that cycle, load the output registers from
//     the slots (including the same-cycle commit) at the next edge and set out_valid;
//   - captured is cleared in the same cycle.
//  If out_valid==1 and out_ready==0 when a frame completes, the frame is dropped,
//   overflow is set (sticky until reset), captured is cleared and outputs are held.
//  Handshake: out_valid stays high and value/blank/err stay stable until the cycle
//   with out_valid&&out_ready. out_valid then clears at the next edge unless a new
//   frame loads in that same cycle, which is back-to-back and keeps out_valid high.
// TESTING
//  1 Reset, DIGITS=6, STABLE=4; drive digits 0..5 with 40,79,24,30,19,12, each held
//    6 cycles, out_ready=1 -> one out_valid pulse, value=24'h543210, blank=0, err=0.
//  2 Digit 2 glitches 24->30 for 2 cycles, then 24 held for 4 cycles
//    -> slot2=2, not 3; there is no commit during the glitch.
//  3 Digit 4 shows 7F and digit 1 shows 55 -> blank=6'b010000, err=6'b000010,
//    value[7:4]=0, value[19:16]=F.
//  4 out_ready=0 across two complete frames -> first frame held stable,
//    overflow=1 after the second, value unchanged; raising out_ready clears out_valid.
//  5 dig_sel=000000 or 000011 held for 20 cycles -> no commit and no out_valid.
//    Pulse reset after 3 digits are captured, then send 6 digits
//    -> frame contains only post-reset data.
//  6 out_ready held high with frames completing every 30 cycles
//    -> exactly one accepted out_valid per frame and overflow stays 0.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for a multiplexed, active-low 7-segment display bus.
// Each digit sample is debounced, decoded into a hex nibble and stored in its
// slot; once every digit has been captured a frame is offered on a valid/ready
// output.
//
// Output handshake: out_valid rises when a frame is loaded, and value/blank/err
// stay stable while out_valid is high. A frame is consumed on any cycle where
// out_valid && out_ready. If a frame completes while the output is occupied and
// not being accepted, that frame is dropped and overflow is set (sticky).
module seg7_scan_decoder #(
  parameter int DIGITS        = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {SETTLE, HOLD} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt, cnt_inc;
  logic [6:0]          seg_q, seg_p;
  logic [DIGITS-1:0]   sel_q, sel_p;
  logic                same, sel_onehot, commit;
  logic [3:0]          dec_nib;
  logic                dec_blank, dec_err;
  logic [4*DIGITS-1:0] slot_val, slot_val_nxt;
  logic [DIGITS-1:0]   slot_blank, slot_blank_nxt;
  logic [DIGITS-1:0]   slot_err, slot_err_nxt;
  logic [DIGITS-1:0]   captured, captured_nxt;
  logic                frame_done;

  // Input stage: current registered sample and the one before it.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= '0;
      sel_q <= '0;
      seg_p <= '0;
      sel_p <= '0;
    end else begin
      seg_q <= seg_n;
      sel_q <= dig_sel;
      seg_p <= seg_q;
      sel_p <= sel_q;
    end
  end

  assign same       = ({seg_q, sel_q} == {seg_p, sel_p});
  assign sel_onehot = $onehot(sel_q);
  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // Pattern decode of the registered sample; unknown patterns flag err.
  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg_q)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h18: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h7F: begin
        dec_nib   = 4'hF;
        dec_blank = 1'b1;
      end
      default: dec_err = 1'b1;
    endcase
  end

  // Debounce FSM state and stability counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SETTLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Debounce FSM: commit once a one-hot sample has been stable long enough.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      SETTLE: begin
        if (!same || !sel_onehot) begin
          cnt_nxt = CNT_ONE;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            commit    = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (!same) begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_ONE;
        end
      end
      default: begin
        state_nxt = SETTLE;
        cnt_nxt   = CNT_ONE;
      end
    endcase
  end

  // Slot and capture-mask next values, including this cycle's commit.
  always_comb begin
    slot_val_nxt   = slot_val;
    slot_blank_nxt = slot_blank;
    slot_err_nxt   = slot_err;
    captured_nxt   = captured;
    for (int i = 0; i < DIGITS; i++) begin
      if (commit && sel_q[i]) begin
        slot_val_nxt[4*i +: 4] = dec_nib;
        slot_blank_nxt[i]      = dec_blank;
        slot_err_nxt[i]        = dec_err;
        captured_nxt[i]        = 1'b1;
      end
    end
  end

  assign frame_done = &captured_nxt;

  // Slot storage; the capture mask restarts whenever a frame completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_val   <= '0;
      slot_blank <= '0;
      slot_err   <= '0;
      captured   <= '0;
    end else begin
      slot_val   <= slot_val_nxt;
      slot_blank <= slot_blank_nxt;
      slot_err   <= slot_err_nxt;
      captured   <= frame_done ? '0 : captured_nxt;
    end
  end

  // Output frame register with valid/ready handshake and drop detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      value     <= '0;
      blank     <= '0;
      err       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (frame_done) begin
      if (!out_valid || out_ready) begin
        value     <= slot_val_nxt;
        blank     <= slot_blank_nxt;
        err       <= slot_err_nxt;
        out_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: a run-length model of the display bus predicts
// committed digits and completed frames; a monitor pops expected frames on
// every accepted handshake.
module tb_seg7_scan_decoder;

  localparam int DIGITS = 6;
  localparam int STABLE = 4;
  localparam int FW     = 6 * DIGITS;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                reset;
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   dig_sel;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   err;
  logic                out_valid;
  logic                out_ready;
  logic                overflow;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .reset(reset), .seg_n(seg_n), .dig_sel(dig_sel),
    .value(value), .blank(blank), .err(err), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow)
  );

  // ---------------- scoreboard state ----------------
  logic [FW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: per-digit slots, capture set, input run length.
  logic [3:0]        m_val   [DIGITS];
  logic              m_blank [DIGITS];
  logic              m_err   [DIGITS];
  logic [DIGITS-1:0] m_cap;
  logic              m_ovf;
  logic [6+DIGITS:0] last_in;
  bit                last_valid;
  int                run;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DIGITS; i++) begin
      m_val[i] = 4'h0; m_blank[i] = 1'b0; m_err[i] = 1'b0;
    end
    m_cap = '0; m_ovf = 1'b0; last_valid = 0; run = 0;
    exp_q.delete();
  endfunction

  function automatic logic [FW-1:0] model_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < DIGITS; i++) begin
      f[4*i +: 4]        = m_val[i];
      f[4*DIGITS + i]    = m_blank[i];
      f[5*DIGITS + i]    = m_err[i];
    end
    return f;
  endfunction

  // A value held for STABLE consecutive cycles on exactly one digit is captured
  // once; the frame goes out when all digits have been seen since the last one.
  function automatic void model_step(input logic [6:0] s, input logic [DIGITS-1:0] sel);
    int idx;
    if (last_valid && ({s, sel} == last_in)) run++;
    else run = 1;
    last_in = {s, sel};
    last_valid = 1;
    if (run == STABLE && $countones(sel) == 1) begin
      idx = 0;
      for (int i = 0; i < DIGITS; i++) if (sel[i]) idx = i;
      m_val[idx] = 4'h0; m_blank[idx] = 1'b0; m_err[idx] = 1'b1;
      if (s == 7'h7F) begin
        m_val[idx] = 4'hF; m_blank[idx] = 1'b1; m_err[idx] = 1'b0;
      end else begin
        for (int k = 0; k < 16; k++)
          if (seg_tab[k] == s) begin m_val[idx] = 4'(k); m_err[idx] = 1'b0; end
      end
      m_cap[idx] = 1'b1;
      if (&m_cap) begin
        m_cap = '0;
        if (exp_q.size() == 0 || out_ready) exp_q.push_back(model_frame());
        else m_ovf = 1'b1;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [6:0] s, input logic [DIGITS-1:0] sel, input int n);
    for (int c = 0; c < n; c++) begin
      seg_n = s;
      dig_sel = sel;
      model_step(s, sel);
      @(posedge clk); #1;
    end
  endtask

  task automatic quiet(input int n);
    apply(7'h7F, '0, n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic send_digit(input int d, input logic [6:0] s, input int hold);
    apply(s, DIGITS'(1) << d, hold);
  endtask

  task automatic send_frame(input logic [6:0] p0, p1, p2, p3, p4, p5, input int hold);
    send_digit(0, p0, hold); send_digit(1, p1, hold); send_digit(2, p2, hold);
    send_digit(3, p3, hold); send_digit(4, p4, hold); send_digit(5, p5, hold);
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      quiet(1);
      c++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d frames still expected after %0d cycles", exp_q.size(), budget);
    end
  endtask

  // ---------------- monitor ----------------
  logic          prev_valid = 1'b0;
  logic          prev_fire  = 1'b0;
  logic [FW-1:0] prev_snap  = '0;

  always @(negedge clk) begin
    logic [FW-1:0] cur, e;
    cur = {err, blank, value};
    if (reset) begin
      prev_valid <= 1'b0;
      prev_fire  <= 1'b0;
    end else begin
      if (out_valid && prev_valid && !prev_fire) check("held_stable", 64'(cur), 64'(prev_snap));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_frame: got %h expected none at %0t", cur, $time);
        end else begin
          e = exp_q.pop_front();
          check("frame", 64'(cur), 64'(e));
        end
      end
      prev_valid <= out_valid;
      prev_fire  <= out_valid && out_ready;
      prev_snap  <= cur;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] pats [DIGITS];
    int         order [DIGITS];
    int         t, hold;
    seg_n = 7'h7F; dig_sel = '0; out_ready = 1'b1; reset = 1'b1;
    model_clear();
    do_reset();

    // Reset state.
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_value", 64'(value), 64'(0));
    check("rst_blank", 64'(blank), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));

    // Straight frame 0..5.
    send_frame(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 6);
    quiet(4); drain(50);

    // Glitch on digit 2 must not commit the glitch value.
    send_digit(0, 7'h00, 6); send_digit(1, 7'h18, 6);
    send_digit(2, 7'h24, 2); send_digit(2, 7'h30, 2); send_digit(2, 7'h24, 4);
    send_digit(3, 7'h08, 6); send_digit(4, 7'h03, 6); send_digit(5, 7'h46, 6);
    quiet(4); drain(50);

    // Blank and undecodable digits.
    send_frame(7'h21, 7'h55, 7'h06, 7'h0E, 7'h7F, 7'h02, 6);
    quiet(4); drain(50);

    // Stalled consumer across two frames: second frame dropped.
    out_ready = 1'b0;
    send_frame(7'h78, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 6);
    quiet(4);
    check("stall_valid", 64'(out_valid), 64'(1));
    send_frame(7'h12, 7'h12, 7'h12, 7'h12, 7'h12, 7'h12, 6);
    quiet(4);
    check("overflow_set", 64'(overflow), 64'(m_ovf));
    out_ready = 1'b1;
    quiet(3);
    check("valid_cleared", 64'(out_valid), 64'(0));
    drain(20);

    // Invalid digit selects never commit.
    apply(7'h40, '0, 20);
    apply(7'h79, DIGITS'(6'b000011), 20);
    quiet(4);
    check("no_commit_valid", 64'(out_valid), 64'(0));

    // Reset mid-frame discards partial captures and overflow.
    send_digit(0, 7'h06, 6); send_digit(1, 7'h06, 6); send_digit(2, 7'h06, 6);
    do_reset();
    check("rst2_overflow", 64'(overflow), 64'(0));
    send_digit(3, 7'h79, 6); send_digit(4, 7'h24, 6); send_digit(5, 7'h30, 6);
    quiet(4);
    check("partial_no_frame", 64'(out_valid), 64'(0));
    send_digit(0, 7'h19, 6); send_digit(1, 7'h12, 6); send_digit(2, 7'h02, 6);
    quiet(4); drain(50);

    // Randomized frames with out_ready held high.
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < DIGITS; i++) begin
        order[i] = i;
        case ($urandom_range(0, 9))
          0:       pats[i] = 7'h7F;
          1:       pats[i] = 7'($urandom_range(0, 127));
          default: pats[i] = seg_tab[$urandom_range(0, 15)];
        endcase
      end
      for (int i = DIGITS - 1; i > 0; i--) begin
        int j;
        j = $urandom_range(0, i);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < DIGITS; i++) begin
        if ($urandom_range(0, 3) == 0)
          send_digit(order[i], 7'($urandom_range(0, 127)), $urandom_range(1, STABLE - 1));
        hold = $urandom_range(STABLE, STABLE + 2);
        send_digit(order[i], pats[order[i]], hold);
      end
      quiet(2);
    end
    quiet(4); drain(100);

    check("final_queue", 64'(exp_q.size()), 64'(0));
    check("final_overflow", 64'(overflow), 64'(m_ovf));
    check("final_valid", 64'(out_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
